// File: rtl/niosii_rst_sequencer.sv
// Avalon-MM controlled reset sequencer: debounced button / software trigger asserts all
// reset domains together, then releases them one by one with HOLD-cycle spacing.
module niosii_rst_sequencer #(
    parameter int unsigned N_DOMAINS = 3,
    parameter int unsigned DB_W      = 16,
    parameter int unsigned HOLD_W    = 16,
    parameter int unsigned DB_RST    = 1000,
    parameter int unsigned HOLD_RST  = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic                 irq,
    input  logic                 btn_n,
    output logic [N_DOMAINS-1:0] rst_out_n,
    output logic                 busy
);

    localparam int unsigned IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
    localparam logic [N_DOMAINS-1:0] ONE_HOT0 = N_DOMAINS'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [HOLD_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d, next_idx;
    logic [N_DOMAINS-1:0] rst_q, rst_d;
    logic                 done_set;

    logic              en_q, ien_q, done_q;
    logic [DB_W-1:0]   deb_q, deb_eff, db_cnt_q;
    logic [DB_W:0]     db_cnt_inc;
    logic [HOLD_W-1:0] hold_q, hold_eff;
    logic [7:0]        trig_cnt_q;

    logic [1:0] sync_q;
    logic       s, db_q, db_hit, btn_trig_q;

    logic wr, wr_ctrl, wr_deb, wr_hold, wr_status, sw_trig, trig;

    assign wr        = chipselect & ~write_n;
    assign wr_ctrl   = wr & (address == 2'd0);
    assign wr_deb    = wr & (address == 2'd1);
    assign wr_hold   = wr & (address == 2'd2);
    assign wr_status = wr & (address == 2'd3);
    assign sw_trig   = wr_ctrl & writedata[0];
    assign trig      = sw_trig | btn_trig_q;

    assign deb_eff  = (deb_q == '0) ? DB_W'(1) : deb_q;
    assign hold_eff = (hold_q == '0) ? HOLD_W'(1) : hold_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q   <= 1'b1;
            ien_q  <= 1'b0;
            deb_q  <= DB_W'(DB_RST);
            hold_q <= HOLD_W'(HOLD_RST);
        end else begin
            if (wr_ctrl) begin
                en_q  <= writedata[1];
                ien_q <= writedata[2];
            end
            if (wr_deb)  deb_q  <= writedata[DB_W-1:0];
            if (wr_hold) hold_q <= writedata[HOLD_W-1:0];
        end
    end

    // Button path: straight into the synchroniser, then a stability counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '1;
        else          sync_q <= {sync_q[0], btn_n};
    end
    assign s = sync_q[1];

    assign db_cnt_inc = {1'b0, db_cnt_q} + {{DB_W{1'b0}}, 1'b1};
    assign db_hit     = db_cnt_inc >= {1'b0, deb_eff};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q       <= 1'b1;
            db_cnt_q   <= '0;
            btn_trig_q <= 1'b0;
        end else begin
            btn_trig_q <= 1'b0;
            if (s == db_q) begin
                db_cnt_q <= '0;
            end else if (db_hit) begin
                db_q       <= s;
                db_cnt_q   <= '0;
                btn_trig_q <= db_q & ~s & en_q;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         trig_cnt_q <= '0;
        else if (trig && trig_cnt_q != 8'hFF) trig_cnt_q <= trig_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
        end
    end

    assign next_idx = idx_q + IDX_W'(1);

    // cnt==0 only occurs after reset: the first ASSERT cycle loads HOLD, so power-on
    // runs one cycle longer than a triggered sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rst_d    = rst_q;
        done_set = 1'b0;
        if (trig) begin
            state_d = ST_ASSERT;
            cnt_d   = hold_eff;
            idx_d   = '0;
            rst_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: rst_d = '1;
                ST_ASSERT: begin
                    rst_d = '0;
                    if (cnt_q == '0) begin
                        cnt_d = hold_eff;
                    end else if (cnt_q == HOLD_W'(1)) begin
                        state_d = ST_RELEASE;
                        idx_d   = '0;
                        rst_d   = ONE_HOT0;
                        cnt_d   = hold_eff;
                    end else begin
                        cnt_d = cnt_q - HOLD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (32'(idx_q) == N_DOMAINS - 1) begin
                        state_d  = ST_DONE;
                        done_set = 1'b1;
                    end else if (cnt_q == HOLD_W'(1)) begin
                        idx_d = next_idx;
                        rst_d = rst_q | (ONE_HOT0 << next_idx);
                        cnt_d = hold_eff;
                    end else begin
                        cnt_d = cnt_q - HOLD_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    rst_d   = '1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     done_q <= 1'b0;
        else if (done_set)                done_q <= 1'b1;
        else if (wr_status && writedata[8]) done_q <= 1'b0;
    end

    assign busy      = (state_q != ST_IDLE);
    assign rst_out_n = rst_q;
    assign irq       = done_q & ien_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= {29'd0, ien_q, en_q, 1'b0};
                2'd1:    readdata <= 32'(deb_q);
                2'd2:    readdata <= 32'(hold_q);
                default: readdata <= {8'd0, trig_cnt_q, 7'd0, done_q, 5'd0, state_q, busy};
            endcase
        end
    end

endmodule

// File: tb/tb_niosii_rst_sequencer.sv
// Randomised and directed bench for niosii_rst_sequencer; outputs are predicted from
// the time elapsed since the last trigger rather than from an FSM replica.
module tb_niosii_rst_sequencer;
    localparam int N   = 3;
    localparam int DBR = 1000;
    localparam int HR  = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic        btn_n = 1'b1;
    logic [N-1:0] rst_out_n;
    logic        busy;

    always #5 clk = ~clk;

    niosii_rst_sequencer #(
        .N_DOMAINS(N), .DB_W(16), .HOLD_W(16), .DB_RST(DBR), .HOLD_RST(HR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .btn_n(btn_n), .rst_out_n(rst_out_n), .busy(busy)
    );

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int edge_cnt = 0;
    int t0 = 1;
    int hs = HR;
    bit m_en = 1, m_ien = 0, m_done = 0, m_pend = 0;
    int m_deb = DBR, m_hold = HR, m_count = 0, m_run = 0;
    bit s1 = 1, s2 = 1, m_db = 1;
    logic [31:0] rd_exp = '0;

    function automatic int h_eff(int v);
        return (v == 0) ? 1 : v;
    endfunction

    // sequence phase as a function of edges elapsed since the trigger edge
    function automatic int state_at(int ec);
        int e = ec - t0;
        if (e < hs)              return 1;
        else if (e < hs * N + 1) return 2;
        else if (e == hs * N + 1) return 3;
        else                     return 0;
    endfunction

    function automatic logic [N-1:0] rst_at(int ec);
        int e = ec - t0;
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = (e >= hs * (k + 1));
        return r;
    endfunction

    always @(posedge clk) begin
        int st;
        bit wr, trig, press;
        if (!reset_n) begin
            edge_cnt++;
            m_en = 1; m_ien = 0; m_done = 0; m_pend = 0;
            m_deb = DBR; m_hold = HR; m_count = 0; m_run = 0;
            s1 = 1; s2 = 1; m_db = 1;
            t0 = edge_cnt + 1;
            hs = h_eff(HR);
            rd_exp = '0;
        end else begin
            st = state_at(edge_cnt);
            case (address)
                2'd0:    rd_exp = {29'd0, m_ien, m_en, 1'b0};
                2'd1:    rd_exp = 32'(m_deb);
                2'd2:    rd_exp = 32'(m_hold);
                default: rd_exp = {8'd0, 8'(m_count), 7'd0, m_done, 5'd0, 2'(st), st != 0};
            endcase
            edge_cnt++;
            wr   = chipselect && !write_n;
            trig = (wr && address == 2'd0 && writedata[0]) || m_pend;
            if (trig) begin
                t0 = edge_cnt;
                hs = h_eff(m_hold);
                if (m_count < 255) m_count++;
            end
            if (!trig && (edge_cnt - t0 == hs * N + 1)) m_done = 1;
            else if (wr && address == 2'd3 && writedata[8]) m_done = 0;
            press = 0;
            if (s2 == m_db) m_run = 0;
            else if (m_run + 1 >= h_eff(m_deb)) begin
                press = m_db && !s2;
                m_db = s2;
                m_run = 0;
            end else m_run++;
            m_pend = press && m_en;
            s2 = s1;
            s1 = btn_n;
            if (wr && address == 2'd0) begin m_en = writedata[1]; m_ien = writedata[2]; end
            if (wr && address == 2'd1) m_deb = int'(writedata[15:0]);
            if (wr && address == 2'd2) m_hold = int'(writedata[15:0]);
        end
    end

    // per-cycle comparison against the model
    always begin
        @(negedge clk);
        #1;
        if (check_en) begin
            if (!reset_n) begin
                chk("rst_val_out", 32'(rst_out_n), 32'd0);
                chk("rst_val_busy", 32'(busy), 32'd1);
                chk("rst_val_irq", 32'(irq), 32'd0);
                chk("rst_val_rd", readdata, 32'd0);
            end else begin
                chk("m_rst_out_n", 32'(rst_out_n), 32'(rst_at(edge_cnt)));
                chk("m_busy", 32'(busy), 32'(state_at(edge_cnt) != 0));
                chk("m_irq", 32'(irq), 32'(m_done & m_ien));
                chk("m_readdata", readdata, rd_exp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        #2;
        d = readdata;
    endtask

    task automatic wait_seq(output int r0, output int r1, output int r2, output int idle);
        r0 = -1; r1 = -1; r2 = -1; idle = -1;
        for (int k = 1; k <= 400 && idle < 0; k++) begin
            @(negedge clk);
            #2;
            if (r0 < 0 && rst_out_n[0]) r0 = k;
            if (r1 < 0 && rst_out_n[1]) r1 = k;
            if (r2 < 0 && rst_out_n[2]) r2 = k;
            if (!busy) idle = k;
        end
    endtask

    task automatic check_seq(input string name, input int h, input bit pwr);
        int r0, r1, r2, idle, off;
        off = pwr ? 1 : 0;
        wait_seq(r0, r1, r2, idle);
        chk({name, "_bit0"}, 32'(r0), 32'(h + off));
        chk({name, "_bit1"}, 32'(r1), 32'(2 * h + off));
        chk({name, "_bit2"}, 32'(r2), 32'(3 * h + off));
        chk({name, "_idle"}, 32'(idle), 32'(3 * h + 2 + off));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int k;
        bit found;

        // 1: power-on sequence with reset defaults
        check_en = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check_seq("pwr", 64, 1'b1);
        rd_reg(2'd3, d);
        chk("pwr_done", 32'(d[8]), 32'd1);
        chk("pwr_count", 32'(d[23:16]), 32'd0);
        rd_reg(2'd1, d);
        chk("pwr_deb", d, 32'd1000);

        // 2: software trigger with HOLD=4
        wr_reg(2'd2, 32'd4);
        wr_reg(2'd0, 32'h3);
        #2 chk("sw_first", 32'(rst_out_n), 32'd0);
        check_seq("sw", 4, 1'b0);
        rd_reg(2'd3, d);
        chk("sw_done", 32'(d[8]), 32'd1);
        chk("sw_count", 32'(d[23:16]), 32'd1);

        // 3: debounce glitch rejection, then one real press
        wr_reg(2'd1, 32'd10);
        btn_n = 1'b0;
        repeat (5) @(negedge clk);
        btn_n = 1'b1;
        repeat (20) @(negedge clk);
        rd_reg(2'd3, d);
        chk("glitch_count", 32'(d[23:16]), 32'd1);
        btn_n = 1'b0;
        repeat (12) @(negedge clk);
        btn_n = 1'b1;
        repeat (40) @(negedge clk);
        rd_reg(2'd3, d);
        chk("press_count", 32'(d[23:16]), 32'd2);
        chk("press_idle", 32'(d[0]), 32'd0);

        // 4: button disabled, IRQ enabled
        wr_reg(2'd0, 32'h4);
        btn_n = 1'b0;
        repeat (20) @(negedge clk);
        btn_n = 1'b1;
        repeat (20) @(negedge clk);
        rd_reg(2'd3, d);
        chk("dis_count", 32'(d[23:16]), 32'd2);
        wr_reg(2'd3, 32'h100);
        #2 chk("irq_clr0", 32'(irq), 32'd0);
        wr_reg(2'd0, 32'h5);
        k = -1;
        for (int i = 1; i <= 50 && k < 0; i++) begin
            @(negedge clk);
            #2;
            if (irq) k = i;
        end
        chk("irq_time", 32'(k), 32'd13);
        wr_reg(2'd3, 32'h100);
        #2 chk("irq_clr1", 32'(irq), 32'd0);

        // 5: restart during RELEASE
        wr_reg(2'd0, 32'h1);
        k = -1;
        for (int i = 1; i <= 50 && k < 0; i++) begin
            @(negedge clk);
            #2;
            if (rst_out_n == 3'b001) k = i;
        end
        chk("rs_bit0", 32'(k), 32'd4);
        repeat (2) @(negedge clk);
        wr_reg(2'd0, 32'h1);
        #2 chk("rs_reassert", 32'(rst_out_n), 32'd0);
        check_seq("rs", 4, 1'b0);
        rd_reg(2'd3, d);
        chk("rs_count", 32'(d[23:16]), 32'd5);

        // 6: coincident button event and SW_RST, then HOLD=0
        wr_reg(2'd0, 32'h2);
        wr_reg(2'd1, 32'd3);
        btn_n = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (m_pend) found = 1'b1;
        end
        chk("coin_pending", 32'(found), 32'd1);
        address = 2'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h3;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        btn_n = 1'b1;
        repeat (30) @(negedge clk);
        rd_reg(2'd3, d);
        chk("coin_count", 32'(d[23:16]), 32'd6);
        wr_reg(2'd2, 32'd0);
        wr_reg(2'd0, 32'h1);
        check_seq("h0", 1, 1'b0);

        // random phase
        wr_reg(2'd2, 32'd3);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (chipselect) begin
                chipselect = 1'b0; write_n = 1'b1;
            end else if ($urandom_range(0, 29) == 0) begin
                logic [1:0] a;
                a = 2'($urandom_range(0, 3));
                if (a == 2'd2 && (state_at(edge_cnt) != 0 || m_pend)) a = 2'd3;
                address = a; chipselect = 1'b1; write_n = 1'b0;
                case (a)
                    2'd0: writedata = {29'd0, 1'b1, 1'b1, ($urandom_range(0, 3) == 0)};
                    2'd1: writedata = 32'($urandom_range(0, 6));
                    2'd2: writedata = 32'($urandom_range(0, 5));
                    default: writedata = $urandom;
                endcase
            end else begin
                address = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 14) == 0) btn_n = ~btn_n;
        end
        chipselect = 1'b0; write_n = 1'b1; btn_n = 1'b1;
        repeat (40) @(negedge clk);

        // reset mid-sequence restarts the power-on sequence
        wr_reg(2'd0, 32'h1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_seq("rst_mid", 64, 1'b1);

        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
